// File: rtl/dmem_mmio.sv
// dmem_mmio: word-addressed data RAM plus a 256-byte MMIO window (LED, synchronised switches, compare timer).
// Define DMEM_MMIO_TIMER_EN to build the MTIME/MTIMECMP/STATUS/CTRL timer; otherwise those offsets read 0.
module dmem_mmio #(
  parameter int          RAM_WORDS = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic [7:0]  sw,
  output logic [7:0]  led,
  output logic        timer_irq
);
  localparam int          IDX_W     = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]      ram_r [RAM_WORDS];
  logic [IDX_W-1:0] idx_s;
  logic             ram_hit_s;
  logic             mmio_hit_s;
  logic [7:0]       off_s;
  logic [7:0]       led_r;
  logic [7:0]       sw_meta_r;
  logic [7:0]       sw_sync_r;
  logic             led_wr_s;
  logic             unused_s;

  assign idx_s      = Adr[IDX_W+1:2];
  assign ram_hit_s  = (Adr < RAM_BYTES);
  assign mmio_hit_s = (Adr[31:8] == MMIO_BASE[31:8]);
  assign off_s      = {Adr[7:2], 2'b00};
  assign led_wr_s   = MemWrite && mmio_hit_s && (off_s == 8'h00);
  assign unused_s   = ^Adr[1:0];
  assign led        = led_r;

  // RAM array: never reset, so a store in a reset cycle still lands.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit_s) begin
      ram_r[idx_s] <= WriteData;
    end
  end

  // LED register and two-flop switch synchroniser.
  always_ff @(posedge clk) begin
    if (!reset) begin
      led_r     <= 8'h00;
      sw_meta_r <= 8'h00;
      sw_sync_r <= 8'h00;
    end else begin
      if (led_wr_s) begin
        led_r <= WriteData[7:0];
      end
      sw_meta_r <= sw;
      sw_sync_r <= sw_meta_r;
    end
  end

`ifdef DMEM_MMIO_TIMER_EN
  logic [31:0] mtime_r;
  logic [31:0] mtimecmp_r;
  logic [1:0]  ctrl_r;
  logic        pending_r;
  logic        match_s;
  logic        mtime_wr_s;
  logic        cmp_wr_s;
  logic        status_wr_s;
  logic        ctrl_wr_s;

  assign mtime_wr_s  = MemWrite && mmio_hit_s && (off_s == 8'h08);
  assign cmp_wr_s    = MemWrite && mmio_hit_s && (off_s == 8'h0C);
  assign status_wr_s = MemWrite && mmio_hit_s && (off_s == 8'h10);
  assign ctrl_wr_s   = MemWrite && mmio_hit_s && (off_s == 8'h14);
  assign match_s     = ctrl_r[0] && (mtime_r == mtimecmp_r);
  assign timer_irq   = pending_r;

  // Timer: an MTIME store beats count/reload; a compare hit beats a STATUS clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mtime_r    <= 32'd0;
      mtimecmp_r <= 32'hFFFF_FFFF;
      ctrl_r     <= 2'b00;
      pending_r  <= 1'b0;
    end else begin
      if (mtime_wr_s) begin
        mtime_r <= WriteData;
      end else if (match_s && ctrl_r[1]) begin
        mtime_r <= 32'd0;
      end else if (ctrl_r[0]) begin
        mtime_r <= mtime_r + 32'd1;
      end
      if (cmp_wr_s) begin
        mtimecmp_r <= WriteData;
      end
      if (ctrl_wr_s) begin
        ctrl_r <= WriteData[1:0];
      end
      if (match_s) begin
        pending_r <= 1'b1;
      end else if (status_wr_s && WriteData[0]) begin
        pending_r <= 1'b0;
      end
    end
  end
`else
  assign timer_irq = 1'b0;
`endif

  // Load path: RAM, then MMIO window by word offset, else zero.
  always_comb begin
    ReadData = 32'd0;
    if (ram_hit_s) begin
      ReadData = ram_r[idx_s];
    end else if (mmio_hit_s) begin
      case (off_s)
        8'h00:   ReadData = {24'd0, led_r};
        8'h04:   ReadData = {24'd0, sw_sync_r};
`ifdef DMEM_MMIO_TIMER_EN
        8'h08:   ReadData = mtime_r;
        8'h0C:   ReadData = mtimecmp_r;
        8'h10:   ReadData = {31'd0, pending_r};
        8'h14:   ReadData = {30'd0, ctrl_r};
`endif
        default: ReadData = 32'd0;
      endcase
    end else begin
      ReadData = 32'd0;
    end
  end
endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed test-plan checks plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_dmem_mmio;
  localparam int          RAM_WORDS = 64;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
`ifdef DMEM_MMIO_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic        timer_irq;

  always #5 clk = ~clk;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
    .ReadData(ReadData), .sw(sw), .led(led), .timer_irq(timer_irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state.
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_vld [RAM_WORDS];
  logic [7:0]  m_led, m_h1, m_h2, m_h3;
  logic [31:0] m_mtime, m_cmp;
  logic [1:0]  m_ctrl;
  logic        m_pend;
  bit          started = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] tv(input logic [31:0] x);
    return TIMER_EN ? x : 32'd0;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a & 32'hFFFF_FF00) == MMIO_BASE;
  endfunction

  function automatic bit mmio_store(input logic [7:0] off);
    logic [7:0] lo;
    lo = Adr[7:0] & 8'hFC;
    return MemWrite && in_mmio(Adr) && (lo == off);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [7:0] o;
    if (a < RAM_BYTES) return m_ram[int'(a / 4)];
    if (!in_mmio(a)) return 32'd0;
    o = a[7:0] & 8'hFC;
    case (o)
      8'h00:   return {24'd0, m_led};
      8'h04:   return {24'd0, m_h2};
      8'h08:   return tv(m_mtime);
      8'h0C:   return tv(m_cmp);
      8'h10:   return tv({31'd0, m_pend});
      8'h14:   return tv({30'd0, m_ctrl});
      default: return 32'd0;
    endcase
  endfunction

  // Model update: applies the rules to the inputs presented during the cycle just ending.
  always @(posedge clk) begin
    started <= 1'b1;
    if (MemWrite && (Adr < RAM_BYTES)) begin
      m_ram[int'(Adr / 4)] <= WriteData;
      m_vld[int'(Adr / 4)] <= 1'b1;
    end
    if (!reset) begin
      m_led <= 8'h00; m_h1 <= 8'h00; m_h2 <= 8'h00; m_h3 <= 8'h00;
      m_mtime <= 32'd0; m_cmp <= 32'hFFFF_FFFF; m_ctrl <= 2'b00; m_pend <= 1'b0;
    end else begin
      if (mmio_store(8'h00)) m_led <= WriteData[7:0];
      m_h1 <= sw; m_h2 <= m_h1; m_h3 <= m_h2;
      if (mmio_store(8'h08)) m_mtime <= WriteData;
      else if (m_ctrl[0]) m_mtime <= (m_ctrl[1] && (m_mtime == m_cmp)) ? 32'd0 : m_mtime + 32'd1;
      if (mmio_store(8'h0C)) m_cmp <= WriteData;
      if (mmio_store(8'h14)) m_ctrl <= WriteData[1:0];
      if (m_ctrl[0] && (m_mtime == m_cmp)) m_pend <= 1'b1;
      else if (mmio_store(8'h10) && WriteData[0]) m_pend <= 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      logic skip;
      logic [7:0] lo;
      lo = Adr[7:0] & 8'hFC;
      skip = 1'b0;
      if ((Adr < RAM_BYTES) && !m_vld[int'(Adr / 4)]) skip = 1'b1;
      if (in_mmio(Adr) && (lo == 8'h04) && (m_h2 != m_h3)) skip = 1'b1;
      if (!skip) check("readdata", ReadData, exp_read(Adr));
      check("led", {24'd0, led}, {24'd0, m_led});
      check("timer_irq", {31'd0, timer_irq}, {31'd0, TIMER_EN & m_pend});
    end
  end

  logic [31:0] rd;
  logic        irq_v;

  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    MemWrite = we; Adr = a; WriteData = d;
    @(negedge clk);
    rd = ReadData; irq_v = timer_irq;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [7:0]  off;
    int          k;
    reset = 1'b0; MemWrite = 1'b0; Adr = 32'd0; WriteData = 32'd0; sw = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Reset state
    step(1'b0, MMIO_BASE + 32'h08, 32'd0); check("rst_mtime", rd, 32'd0);
    step(1'b0, MMIO_BASE + 32'h0C, 32'd0); check("rst_cmp", rd, tv(32'hFFFF_FFFF));
    step(1'b0, MMIO_BASE + 32'h14, 32'd0); check("rst_ctrl", rd, 32'd0);
    check("rst_irq", {31'd0, irq_v}, 32'd0);
    check("rst_led", {24'd0, led}, 32'd0);

    // RAM store/load
    step(1'b1, 32'h10, 32'hDEAD_BEEF);
    step(1'b0, 32'h10, 32'd0);  check("ram_10", rd, 32'hDEAD_BEEF);
    step(1'b0, 32'h13, 32'd0);  check("ram_13", rd, 32'hDEAD_BEEF);
    step(1'b0, 32'h100, 32'd0); check("unmapped", rd, 32'd0);

    // LED and SW
    step(1'b1, MMIO_BASE, 32'h1A5);
    step(1'b0, MMIO_BASE, 32'd0); check("led_rd", rd, 32'h0000_00A5);
    check("led_pin", {24'd0, led}, 32'h0000_00A5);
    sw = 8'h3C;
    repeat (3) step(1'b0, MMIO_BASE + 32'h04, 32'd0);
    step(1'b0, MMIO_BASE + 32'h04, 32'd0); check("sw_sync", rd, 32'h3C);

    // Timer one-shot
    step(1'b1, MMIO_BASE + 32'h0C, 32'd5);
    step(1'b1, MMIO_BASE + 32'h08, 32'd0);
    step(1'b1, MMIO_BASE + 32'h14, 32'd1);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, MMIO_BASE + 32'h08, 32'd0);
      check("oneshot_mtime", rd, tv(32'(i)));
      check("oneshot_irq", {31'd0, irq_v}, {31'd0, TIMER_EN && (i >= 6)});
    end
    step(1'b1, MMIO_BASE + 32'h10, 32'd1);  check("irq_before_clr", {31'd0, irq_v}, {31'd0, TIMER_EN});
    step(1'b1, MMIO_BASE + 32'h0C, 32'd12); check("irq_cleared", {31'd0, irq_v}, 32'd0);
    step(1'b0, MMIO_BASE + 32'h08, 32'd0);  check("mtime_10", rd, tv(32'd10));
    step(1'b0, MMIO_BASE + 32'h08, 32'd0);
    step(1'b1, MMIO_BASE + 32'h10, 32'd1);
    step(1'b0, MMIO_BASE + 32'h10, 32'd0);  check("set_beats_clr", rd, tv(32'd1));
    check("set_beats_clr_irq", {31'd0, irq_v}, {31'd0, TIMER_EN});
    step(1'b1, MMIO_BASE + 32'h10, 32'd3);
    step(1'b0, MMIO_BASE + 32'h10, 32'd0);  check("clr_again", rd, 32'd0);

    // MTIME store while counting
    step(1'b1, MMIO_BASE + 32'h08, 32'd100);
    step(1'b0, MMIO_BASE + 32'h08, 32'd0);  check("mtime_100", rd, tv(32'd100));
    step(1'b0, MMIO_BASE + 32'h08, 32'd0);  check("mtime_101", rd, tv(32'd101));

    // Autoreload, period 4
    step(1'b1, MMIO_BASE + 32'h14, 32'd0);
    step(1'b1, MMIO_BASE + 32'h08, 32'd0);
    step(1'b1, MMIO_BASE + 32'h0C, 32'd3);
    step(1'b1, MMIO_BASE + 32'h10, 32'd1);
    step(1'b1, MMIO_BASE + 32'h14, 32'hFFFF_FFFF);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, MMIO_BASE + 32'h08, 32'd0);
      check("reload_mtime", rd, tv(32'(i % 4)));
      check("reload_irq", {31'd0, irq_v}, {31'd0, TIMER_EN && (i >= 4)});
    end
    step(1'b0, MMIO_BASE + 32'h14, 32'd0);  check("ctrl_rd", rd, tv(32'd3));

    // Reset mid-count: MMIO store dropped, RAM store kept
    reset = 1'b0;
    step(1'b1, MMIO_BASE, 32'h77);
    step(1'b1, 32'h20, 32'h1234_5678);
    reset = 1'b1;
    step(1'b0, MMIO_BASE + 32'h08, 32'd0);  check("mid_rst_mtime", rd, 32'd0);
    check("mid_rst_irq", {31'd0, irq_v}, 32'd0);
    check("mid_rst_led", {24'd0, led}, 32'd0);
    step(1'b0, MMIO_BASE + 32'h0C, 32'd0);  check("mid_rst_cmp", rd, tv(32'hFFFF_FFFF));
    step(1'b0, MMIO_BASE + 32'h14, 32'd0);  check("mid_rst_ctrl", rd, 32'd0);
    step(1'b0, 32'h10, 32'd0);              check("ram_kept", rd, 32'hDEAD_BEEF);
    step(1'b0, 32'h20, 32'd0);              check("ram_in_rst", rd, 32'h1234_5678);

    // Randomized traffic, checked by the compare process
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
      k = $urandom_range(0, 9);
      d = $urandom;
      if (k <= 3) begin
        a = 32'($urandom_range(0, 255));
      end else if (k <= 7) begin
        off = 8'($urandom_range(0, 7) * 4);
        a = MMIO_BASE + {24'd0, off};
        if (off == 8'h08) d = 32'($urandom_range(0, 40));
        if (off == 8'h0C) d = 32'($urandom_range(0, 60));
      end else if (k == 8) begin
        a = $urandom;
      end else begin
        a = MMIO_BASE + 32'h08;
      end
      step(1'($urandom_range(0, 1)), a, d);
    end

    reset = 1'b1;
    step(1'b0, 32'h10, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
